// File: rtl/regfile_pkg.sv
// Register file package: default sizes and the datapath word type.
// Shared by the register file, its read ports and the bus interface.
package regfile_pkg;

    localparam int RF_DW_DEF    = 10;
    localparam int RF_DEPTH_DEF = 4;

    typedef logic [RF_DW_DEF-1:0] rf_word_t;

endpackage

// File: rtl/regfile_param_if.sv
// Register file bus: write, reserve and read-port signals.
// master = controller side, slave = register file side.
interface regfile_param_if
    import regfile_pkg::*;
#(
    parameter int DW    = RF_DW_DEF,
    parameter int DEPTH = RF_DEPTH_DEF,
    parameter int NRP   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]     D;
    logic              ENW;
    logic [AW-1:0]     WRA;
    logic              ENRSV;
    logic [AW-1:0]     RSVA;
    logic [NRP-1:0]    ENR;
    logic [NRP*AW-1:0] RDA;
    logic [NRP*DW-1:0] Q;
    logic [NRP-1:0]    QV;
    logic [DEPTH-1:0]  BUSY;

    modport master (
        output D, ENW, WRA, ENRSV, RSVA, ENR, RDA,
        input  Q, QV, BUSY
    );

    modport slave (
        input  D, ENW, WRA, ENRSV, RSVA, ENR, RDA,
        output Q, QV, BUSY
    );

endinterface

// File: rtl/regfile_rdport.sv
// One register file read port: range check, write forwarding, pending/valid.
// Ports: clk/rst, en, rda, regs/busy snapshot, wen/wra/d bypass, q/qv out.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int READ_REG = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [AW-1:0]              rda,
    input  logic [DEPTH-1:0][DW-1:0]   regs,
    input  logic [DEPTH-1:0]           busy,
    input  logic                       wen,
    input  logic [AW-1:0]              wra,
    input  logic [DW-1:0]              d,
    output logic [DW-1:0]              q,
    output logic                       qv
);

    logic [DW-1:0] sel;
    logic          pend;
    logic          in_range;
    logic          zero_hit;
    logic          fwd;
    logic [DW-1:0] nq;
    logic          nqv;

    // Loop mux keeps out-of-range addresses from indexing past the array.
    always_comb begin
        sel  = '0;
        pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rda == AW'(i)) begin
                sel  = regs[i];
                pend = busy[i];
            end
        end
    end

    always_comb begin
        in_range = 32'(rda) < DEPTH;
        zero_hit = (R0_ZERO != 0) && (rda == '0);
        fwd      = wen && (wra == rda);
        nq       = '0;
        nqv      = 1'b0;
        if (en && in_range) begin
            if (zero_hit) begin
                nqv = 1'b1;
            end else if (fwd) begin
                // A same-edge write both supplies the data and clears pending.
                nq  = d;
                nqv = 1'b1;
            end else begin
                nq  = sel;
                nqv = !pend;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg
            always_ff @(negedge clk) begin
                if (rst) begin
                    q  <= '0;
                    qv <= 1'b0;
                end else begin
                    q  <= nq;
                    qv <= nqv;
                end
            end
        end else begin : g_comb
            assign q  = nq;
            assign qv = nqv;
        end
    endgenerate

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with forwarding, optional zero R0 and pending bits.
// Ports: CLKb (falling-edge clock), RST (sync, active-high), bus (slave).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRP      = 2,
    parameter int READ_REG = 1,
    parameter int R0_ZERO  = 0
) (
    input logic            CLKb,
    input logic            RST,
    regfile_param_if.slave bus
);

    logic [DEPTH-1:0][DW-1:0] regs;
    logic [DEPTH-1:0]         busy;
    logic                     wr_ok;
    logic                     rs_ok;
    logic [NRP*DW-1:0]        q_all;
    logic [NRP-1:0]           qv_all;

    // Out-of-range and (when hard-wired) register-0 targets are dropped.
    always_comb begin
        wr_ok = bus.ENW && (32'(bus.WRA) < DEPTH)
             && !((R0_ZERO != 0) && (bus.WRA == '0));
        rs_ok = bus.ENRSV && (32'(bus.RSVA) < DEPTH)
             && !((R0_ZERO != 0) && (bus.RSVA == '0));
    end

    always_ff @(negedge CLKb) begin
        if (RST) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (bus.WRA == AW'(i))) begin
                    regs[i] <= bus.D;
                    busy[i] <= 1'b0;
                end
                // Reserve is applied last so it wins over a same-edge write.
                if (rs_ok && (bus.RSVA == AW'(i))) begin
                    busy[i] <= 1'b1;
                end
            end
        end
    end

    genvar p;
    generate
        for (p = 0; p < NRP; p++) begin : g_rd
            regfile_rdport #(
                .DW       (DW),
                .DEPTH    (DEPTH),
                .AW       (AW),
                .READ_REG (READ_REG),
                .R0_ZERO  (R0_ZERO)
            ) u_rd (
                .clk  (CLKb),
                .rst  (RST),
                .en   (bus.ENR[p]),
                .rda  (bus.RDA[p*AW +: AW]),
                .regs (regs),
                .busy (busy),
                .wen  (bus.ENW),
                .wra  (bus.WRA),
                .d    (bus.D),
                .q    (q_all[p*DW +: DW]),
                .qv   (qv_all[p])
            );
        end
    endgenerate

    assign bus.Q    = q_all;
    assign bus.QV   = qv_all;
    assign bus.BUSY = busy;

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: vector table on the default build,
// hand sequences for the zero-R0 and 6-deep/3-port builds.
module tb_regfile_param;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_param_if #(.DW(10), .DEPTH(4), .NRP(2)) b0 ();
    regfile_param_if #(.DW(10), .DEPTH(4), .NRP(2)) b1 ();
    regfile_param_if #(.DW(10), .DEPTH(6), .NRP(3)) b2 ();

    regfile_param #(
        .DW(10), .DEPTH(4), .NRP(2), .READ_REG(1), .R0_ZERO(0)
    ) u0 (.CLKb(clk), .RST(rst), .bus(b0.slave));

    regfile_param #(
        .DW(10), .DEPTH(4), .NRP(2), .READ_REG(1), .R0_ZERO(1)
    ) u1 (.CLKb(clk), .RST(rst), .bus(b1.slave));

    regfile_param #(
        .DW(10), .DEPTH(6), .NRP(3), .READ_REG(1), .R0_ZERO(0)
    ) u2 (.CLKb(clk), .RST(rst), .bus(b2.slave));

    typedef struct {
        logic       rst;
        logic       enw;
        logic [1:0] wra;
        rf_word_t   d;
        logic       enrsv;
        logic [1:0] rsva;
        logic [1:0] enr;
        logic [1:0] ra0;
        logic [1:0] ra1;
        rf_word_t   q0;
        rf_word_t   q1;
        logic [1:0] qv;
        logic [3:0] busy;
    } vec_t;

    vec_t tv[19];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        b0.D = '0; b0.ENW = 0; b0.WRA = '0; b0.ENRSV = 0;
        b0.RSVA = '0; b0.ENR = '0; b0.RDA = '0;
        b1.D = '0; b1.ENW = 0; b1.WRA = '0; b1.ENRSV = 0;
        b1.RSVA = '0; b1.ENR = '0; b1.RDA = '0;
        b2.D = '0; b2.ENW = 0; b2.WRA = '0; b2.ENRSV = 0;
        b2.RSVA = '0; b2.ENR = '0; b2.RDA = '0;
    endtask

    initial begin
        //        rst enw wra d       rsv rsa enr r0 r1 q0      q1      qv     busy
        tv[0]  = '{1, 0, 0, 10'h000, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[1]  = '{0, 1, 0, 10'h3FF, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[2]  = '{0, 1, 1, 10'h3FF, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[3]  = '{0, 1, 2, 10'h3FF, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[4]  = '{0, 1, 3, 10'h3FF, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[5]  = '{0, 0, 0, 10'h000, 0, 0, 2'b11, 0, 3, 10'h3FF, 10'h3FF, 2'b11, 4'b0000};
        tv[6]  = '{1, 1, 1, 10'h123, 1, 2, 2'b11, 1, 2, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[7]  = '{0, 0, 0, 10'h000, 0, 0, 2'b11, 0, 3, 10'h000, 10'h000, 2'b11, 4'b0000};
        tv[8]  = '{0, 1, 2, 10'h155, 0, 0, 2'b00, 0, 0, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[9]  = '{0, 0, 0, 10'h000, 0, 0, 2'b11, 2, 2, 10'h155, 10'h155, 2'b11, 4'b0000};
        tv[10] = '{0, 1, 1, 10'h2AA, 0, 0, 2'b01, 1, 0, 10'h2AA, 10'h000, 2'b01, 4'b0000};
        tv[11] = '{0, 0, 0, 10'h000, 0, 0, 2'b11, 1, 0, 10'h2AA, 10'h000, 2'b11, 4'b0000};
        tv[12] = '{0, 0, 0, 10'h000, 1, 3, 2'b11, 3, 2, 10'h000, 10'h155, 2'b11, 4'b1000};
        tv[13] = '{0, 0, 0, 10'h000, 0, 0, 2'b11, 3, 3, 10'h000, 10'h000, 2'b00, 4'b1000};
        tv[14] = '{0, 1, 3, 10'h07F, 0, 0, 2'b01, 3, 0, 10'h07F, 10'h000, 2'b01, 4'b0000};
        tv[15] = '{0, 1, 2, 10'h0AB, 1, 2, 2'b10, 0, 2, 10'h000, 10'h0AB, 2'b10, 4'b0100};
        tv[16] = '{0, 0, 0, 10'h000, 0, 0, 2'b11, 1, 3, 10'h2AA, 10'h07F, 2'b11, 4'b0100};
        tv[17] = '{1, 1, 1, 10'h3FF, 1, 0, 2'b11, 1, 2, 10'h000, 10'h000, 2'b00, 4'b0000};
        tv[18] = '{0, 0, 0, 10'h000, 0, 0, 2'b11, 1, 2, 10'h000, 10'h000, 2'b11, 4'b0000};

        idle_all();
        rst = 1'b1;
        #1;
        tick();

        for (int i = 0; i < 19; i++) begin
            rst      = tv[i].rst;
            b0.ENW   = tv[i].enw;
            b0.WRA   = tv[i].wra;
            b0.D     = tv[i].d;
            b0.ENRSV = tv[i].enrsv;
            b0.RSVA  = tv[i].rsva;
            b0.ENR   = tv[i].enr;
            b0.RDA   = {tv[i].ra1, tv[i].ra0};
            tick();
            chk($sformatf("v%0d q0", i), 32'(b0.Q[9:0]), 32'(tv[i].q0));
            chk($sformatf("v%0d q1", i), 32'(b0.Q[19:10]), 32'(tv[i].q1));
            chk($sformatf("v%0d qv", i), 32'(b0.QV), 32'(tv[i].qv));
            chk($sformatf("v%0d busy", i), 32'(b0.BUSY), 32'(tv[i].busy));
        end

        // Hard-wired zero register
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b1.ENW = 1; b1.WRA = 2'd0; b1.D = 10'h3FF;
        b1.ENRSV = 1; b1.RSVA = 2'd0;
        tick();
        chk("r0z busy after rsv0", 32'(b1.BUSY), 32'h0);
        b1.ENRSV = 0;
        b1.WRA = 2'd1; b1.D = 10'h3FF;
        tick();
        b1.ENW = 0;
        b1.ENR = 2'b11; b1.RDA = {2'd1, 2'd0};
        tick();
        chk("r0z q0", 32'(b1.Q[9:0]), 32'h0);
        chk("r0z q1", 32'(b1.Q[19:10]), 32'h3FF);
        chk("r0z qv", 32'(b1.QV), 32'h3);
        chk("r0z busy", 32'(b1.BUSY), 32'h0);

        // Six-deep, three-port build: out-of-range address handling
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b2.ENW = 1; b2.WRA = 3'd5; b2.D = 10'h1A5;
        tick();
        b2.WRA = 3'd7; b2.D = 10'h3FF;
        b2.ENRSV = 1; b2.RSVA = 3'd7;
        tick();
        chk("d6 busy rsv7", 32'(b2.BUSY), 32'h0);
        b2.ENW = 0; b2.ENRSV = 0;
        b2.ENR = 3'b111; b2.RDA = {3'd0, 3'd5, 3'd7};
        tick();
        chk("d6 q0 oor", 32'(b2.Q[9:0]), 32'h0);
        chk("d6 q1", 32'(b2.Q[19:10]), 32'h1A5);
        chk("d6 q2", 32'(b2.Q[29:20]), 32'h0);
        chk("d6 qv", 32'(b2.QV), 32'h6);
        b2.ENRSV = 1; b2.RSVA = 3'd4;
        b2.RDA = {3'd4, 3'd6, 3'd4};
        tick();
        chk("d6 busy rsv4", 32'(b2.BUSY), 32'h10);
        chk("d6 qv rsv4", 32'(b2.QV), 32'h5);
        b2.ENRSV = 0;
        tick();
        chk("d6 qv pend", 32'(b2.QV), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
